nco_tdm: RTL and testbench
==========================

Name: nco_tdm

Overview:
- Parametrised, time-division-multiplexed numerically controlled oscillator producing signed sin/cos samples for CHANNELS independent tones through one shared pipeline.
- Successor to the single-channel 32-bit/14-bit NCO. Adds per-channel tuning registers, accumulator sync, quarter-wave LUT compression and channel-tagged output.
- Feeds the mixer/DDC datapath.

Parameters:
- ACC_W, 32: phase accumulator and increment width.
- PHASE_W, 16: truncated phase width and phase_mod_i width.
- LUT_AW, 10: quarter-wave table address bits; LUT_AW+2 <= PHASE_W.
- OUT_W, 14: signed sin/cos output width.
- CHANNELS, 4: number of time-multiplexed channels, >= 1.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: reset, synchronous, active-low.
- clken, in, 1: global enable; when low all state holds.
- cfg_we, in, 1: write phi_inc for channel cfg_ch.
- cfg_ch, in, CH_W = max(1,$clog2(CHANNELS)): channel index for the write.
- cfg_phi_inc, in, ACC_W: phase increment value.
- freq_mod_i, in, ACC_W: added to the increment of the channel in the current slot.
- phase_mod_i, in, PHASE_W: added to the truncated phase of the current slot.
- sync_i, in, 1: clears all accumulators.
- fsin_o, out, OUT_W: two's-complement sine.
- fcos_o, out, OUT_W: two's-complement cosine.
- out_ch, out, CH_W: channel index of the current output sample.
- out_valid, out, 1: output sample valid.

Behaviour:
- Reset (reset_n=0 at posedge, regardless of clken) clears all of the following; effect takes place at that edge:
  - acc[], phi_inc[], slot, valid pipe.
  - fsin_o, fcos_o, out_ch, out_valid all go to 0.
- clken=0: no register changes, except that cfg writes are still accepted. Outputs and out_valid hold.
- Slot counter: advances 0..CHANNELS-1 and wraps on each enabled cycle.
- S0, on an enabled cycle with slot s:
  - p <= acc[s][ACC_W-1 -: PHASE_W] + phase_mod_i, mod 2^PHASE_W.
  - acc[s] <= acc[s] + phi_inc[s] + freq_mod_i, mod 2^ACC_W.
  - The sample therefore uses the pre-update accumulator.
- S1:
  - idx = p[PHASE_W-1 -: LUT_AW+2].
  - Sine: quadrant qs = idx[top 2], addr a = idx[LUT_AW-1:0].
  - Cosine: uses idx + 2^LUT_AW, mod 2^(LUT_AW+2).
  - For each of the two: addr = q[0] ? ~a : a; neg = q[1].
- S2: registered dual-read ROM.
  - L[k] = round((2^(OUT_W-1)-1) * sin(pi/2*(k+0.5)/2^LUT_AW)).
  - The half-sample offset makes the mirror exact.
- S3: output register = neg ? -L : L.
  - |L| <= 2^(OUT_W-1)-1, so negation never overflows.
  - out_ch is the slot index delayed 3 stages.
- Latency: 4 enabled cycles from slot presentation at S0 to the output register.
- out_valid: 0 until the first sample reaches S3, i.e. it rises on the 4th enabled edge after reset release, then stays 1.
- cfg write to channel s in the same cycle s is in S0:
  - S0 uses the old phi_inc.
  - The new value is stored and applies from the next visit.
- sync_i=1 on an enabled cycle:
  - all acc <= 0; sync wins over the S0 update.
  - The S0 sample of that cycle still uses the pre-sync acc.
  - slot is not reset.
- Wrap-around of acc and p is modular; no saturation.

Optional Feature:
- NCO_DITHER_EN defined:
  - 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1 on reset.
  - Advances each enabled cycle.
  - Its low (PHASE_W-LUT_AW-2) bits are added to p before truncation in S1.
  - Reduces spurs; latency unchanged.
- Not defined: no LFSR; outputs are fully deterministic.

Decomposition:
- Package nco_pkg holds:
  - default widths;
  - the quadrant decode function;
  - the LUT entry function (used to build the ROM at elaboration);
  - the LFSR tap constant.
- Sub-module nco_quarter_lut: parameters LUT_AW and OUT_W; two addresses in, two registered OUT_W-1-bit magnitudes out, one clock-enable.

Test Plan:
- Single tone: defaults except CHANNELS=1, phi_inc=2^30, mods 0.
  - sin repeats 6, 8191, -6, -8191.
  - cos repeats 8191, -6, -8191, 6.
  - out_valid rises on the 4th edge after reset release.
- Multi-channel: CHANNELS=4, phi_inc = {2^30, 2^31, 0, 2^30}.
  - out_ch cycles 0,1,2,3.
  - ch2 sin constant 6.
  - ch1 sin alternates 6, -6.
  - ch0 and ch3 match the single-tone sequence.
- Phase mod: phi_inc=0, phase_mod_i=16384 -> sin=8191, cos=-6 after 4 cycles. Freq mod: freq_mod_i=2^30 with phi_inc=0 reproduces the single-tone sequence.
- clken gaps: random clken=0 bursts -> output sequence identical to the ungated run, and outputs hold during gaps.
- sync/cfg/reset collisions:
  - sync_i together with the slot update -> next visit samples phase 0 (sin 6).
  - cfg write during own slot -> new increment applies one visit later.
  - reset_n=0 mid-stream -> all outputs 0 and out_valid=0 at the next edge.
- NCO_DITHER_EN:
  - With the macro, the first 4 LFSR states match the golden model and mean sin error stays within ±2 LSB.
  - Without the macro, output equals the scenario 1 golden sequence.

Source files
------------

// File: rtl/nco_pkg.sv
// ----------------------------------------------------------------------------
// nco_pkg: shared widths, quadrant decode, quarter-wave table entry, LFSR taps.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nco_pkg;

  localparam int DEF_ACC_W    = 32;
  localparam int DEF_PHASE_W  = 16;
  localparam int DEF_LUT_AW   = 10;
  localparam int DEF_OUT_W    = 14;
  localparam int DEF_CHANNELS = 4;

  // x^16+x^14+x^13+x^11+1 as a right-shifting register (feedback into bit 15)
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic mirror;
    logic neg;
  } quad_t;

  function automatic quad_t quad_decode(input logic [1:0] q);
    quad_t r;
    r.mirror = q[0];
    r.neg    = q[1];
    return r;
  endfunction

  // pi in Q60; 128-bit intermediates keep the series error far below one LSB.
  localparam logic signed [127:0] PI_Q60 = 128'sh3243_F6A8_885A_308D;

  // round((2^(ow-1)-1) * sin(pi/2*(k+0.5)/2^aw)) via Taylor series
  function automatic int lut_entry(input int k, input int aw, input int ow);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] amp;
    x    = (PI_Q60 * 128'(2 * k + 1)) >>> (aw + 2);
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (-((term * x2) >>> 60)) / 128'(2 * n * (2 * n + 1));
      sum  = sum + term;
    end
    amp = 128'((1 << (ow - 1)) - 1);
    amp = ((sum * amp) + (128'sd1 <<< 59)) >>> 60;
    return int'(amp[31:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nco_quarter_lut.sv
// ----------------------------------------------------------------------------
// nco_quarter_lut: dual-read registered quarter-wave sine magnitude ROM.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int LUT_AW = DEF_LUT_AW,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [LUT_AW-1:0] addr_sin_i,
  input  logic [LUT_AW-1:0] addr_cos_i,
  output logic [OUT_W-2:0]  mag_sin_o,
  output logic [OUT_W-2:0]  mag_cos_o
);

  localparam int DEPTH = 2 ** LUT_AW;

  logic [OUT_W-2:0] rom [DEPTH];
  logic [OUT_W-2:0] mag_sin_q;
  logic [OUT_W-2:0] mag_cos_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int ENTRY = lut_entry(k, LUT_AW, OUT_W);
    assign rom[k] = ENTRY[OUT_W-2:0];
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mag_sin_q <= rom[addr_sin_i];
      mag_cos_q <= rom[addr_cos_i];
    end
  end

  assign mag_sin_o = mag_sin_q;
  assign mag_cos_o = mag_cos_q;

endmodule

`default_nettype wire

// File: rtl/nco_tdm.sv
// ----------------------------------------------------------------------------
// nco_tdm: time-multiplexed multi-channel sin/cos NCO; NCO_DITHER_EN adds LFSR phase dither.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nco_tdm
  import nco_pkg::*;
#(
  parameter int ACC_W    = DEF_ACC_W,
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int LUT_AW   = DEF_LUT_AW,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [ACC_W-1:0]        cfg_phi_inc,
  input  logic [ACC_W-1:0]        freq_mod_i,
  input  logic [PHASE_W-1:0]      phase_mod_i,
  input  logic                    sync_i,
  output logic signed [OUT_W-1:0] fsin_o,
  output logic signed [OUT_W-1:0] fcos_o,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid
);

  localparam int IDX_W  = LUT_AW + 2;
  localparam int DITH_W = PHASE_W - IDX_W;
  localparam logic [IDX_W-1:0] QUARTER = {2'b01, {LUT_AW{1'b0}}};

  // S0 state
  logic [ACC_W-1:0]   acc_q [CHANNELS];
  logic [ACC_W-1:0]   phi_inc_q [CHANNELS];
  logic [CH_W-1:0]    slot_q;
  logic [CH_W-1:0]    slot_d;
  logic [ACC_W-1:0]   acc_cur;
  logic [ACC_W-1:0]   acc_d;
  logic [PHASE_W-1:0] p_d;

  // pipeline registers
  logic [PHASE_W-1:0] p_q;
  logic [CH_W-1:0]    ch_s0_q, ch_s1_q, ch_s2_q, out_ch_q;
  logic [3:0]         vld_q;
  logic [LUT_AW-1:0]  addr_sin_q, addr_cos_q;
  logic [LUT_AW-1:0]  addr_sin_d, addr_cos_d;
  logic               neg_sin_s1_q, neg_cos_s1_q;
  logic               neg_sin_s2_q, neg_cos_s2_q;
  logic [OUT_W-2:0]   mag_sin, mag_cos;
  logic [OUT_W-1:0]   fsin_q, fcos_q, fsin_d, fcos_d;

  // S1 decode
  logic [PHASE_W-1:0] p_eff;
  logic [IDX_W-1:0]   idx_sin, idx_cos;
  logic [DITH_W-1:0]  p_unused;
  quad_t              q_sin, q_cos;
  logic [OUT_W-1:0]   sin_ext, cos_ext;

  always_comb begin
    acc_cur = acc_q[slot_q];
    acc_d   = acc_cur + phi_inc_q[slot_q] + freq_mod_i;
    p_d     = acc_cur[ACC_W-1 -: PHASE_W] + phase_mod_i;
    slot_d  = (slot_q == CH_W'(CHANNELS - 1)) ? '0 : slot_q + 1'b1;
  end

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (clken) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign p_eff = p_q + PHASE_W'(lfsr_q[DITH_W-1:0]);
`else
  assign p_eff = p_q;
`endif

  always_comb begin
    {idx_sin, p_unused} = p_eff;
    idx_cos    = idx_sin + QUARTER;
    q_sin      = quad_decode(idx_sin[IDX_W-1 -: 2]);
    q_cos      = quad_decode(idx_cos[IDX_W-1 -: 2]);
    addr_sin_d = q_sin.mirror ? ~idx_sin[LUT_AW-1:0] : idx_sin[LUT_AW-1:0];
    addr_cos_d = q_cos.mirror ? ~idx_cos[LUT_AW-1:0] : idx_cos[LUT_AW-1:0];
  end

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk        (clk),
    .en_i       (clken),
    .addr_sin_i (addr_sin_q),
    .addr_cos_i (addr_cos_q),
    .mag_sin_o  (mag_sin),
    .mag_cos_o  (mag_cos)
  );

  // magnitudes never reach 2^(OUT_W-1), so the negation cannot overflow
  always_comb begin
    sin_ext = {1'b0, mag_sin};
    cos_ext = {1'b0, mag_cos};
    fsin_d  = neg_sin_s2_q ? -sin_ext : sin_ext;
    fcos_d  = neg_cos_s2_q ? -cos_ext : cos_ext;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]     <= '0;
        phi_inc_q[c] <= '0;
      end
      slot_q       <= '0;
      p_q          <= '0;
      ch_s0_q      <= '0;
      ch_s1_q      <= '0;
      ch_s2_q      <= '0;
      out_ch_q     <= '0;
      vld_q        <= '0;
      addr_sin_q   <= '0;
      addr_cos_q   <= '0;
      neg_sin_s1_q <= 1'b0;
      neg_cos_s1_q <= 1'b0;
      neg_sin_s2_q <= 1'b0;
      neg_cos_s2_q <= 1'b0;
      fsin_q       <= '0;
      fcos_q       <= '0;
    end else begin
      // configuration writes bypass clken; S0 still reads the old increment this cycle
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c))) begin
          phi_inc_q[c] <= cfg_phi_inc;
        end
      end
      if (clken) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (sync_i) begin
            acc_q[c] <= '0;
          end else if (slot_q == CH_W'(c)) begin
            acc_q[c] <= acc_d;
          end
        end
        slot_q       <= slot_d;
        p_q          <= p_d;
        ch_s0_q      <= slot_q;
        addr_sin_q   <= addr_sin_d;
        addr_cos_q   <= addr_cos_d;
        neg_sin_s1_q <= q_sin.neg;
        neg_cos_s1_q <= q_cos.neg;
        ch_s1_q      <= ch_s0_q;
        neg_sin_s2_q <= neg_sin_s1_q;
        neg_cos_s2_q <= neg_cos_s1_q;
        ch_s2_q      <= ch_s1_q;
        vld_q        <= {vld_q[2:0], 1'b1};
        if (vld_q[2]) begin
          fsin_q   <= fsin_d;
          fcos_q   <= fcos_d;
          out_ch_q <= ch_s2_q;
        end
      end
    end
  end

  assign fsin_o    = fsin_q;
  assign fcos_o    = fcos_q;
  assign out_ch    = out_ch_q;
  assign out_valid = vld_q[3];

endmodule

`default_nettype wire

// File: tb/tb_nco_tdm.sv
// ----------------------------------------------------------------------------
// tb_nco_tdm: directed and randomized checks of nco_tdm against a trigonometric reference.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nco_tdm;

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 8191.0;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clken;
  logic               cfg_we;
  logic [1:0]         cfg_ch;
  logic [31:0]        cfg_phi_inc;
  logic [31:0]        freq_mod_i;
  logic [15:0]        phase_mod_i;
  logic               sync_i;
  logic signed [13:0] fsin_o;
  logic signed [13:0] fcos_o;
  logic [1:0]         out_ch;
  logic               out_valid;

  int n_vec = 0;
  int n_err = 0;

  nco_tdm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clken       (clken),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_phi_inc (cfg_phi_inc),
    .freq_mod_i  (freq_mod_i),
    .phase_mod_i (phase_mod_i),
    .sync_i      (sync_i),
    .fsin_o      (fsin_o),
    .fcos_o      (fcos_o),
    .out_ch      (out_ch),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  // reference: per-channel phase state plus a 4-deep latency queue of finished samples
  typedef struct {
    int s;
    int c;
    int ch;
  } samp_t;

  bit [31:0]   m_acc [4];
  bit [31:0]   m_phi [4];
  int          m_slot;
  bit [15:0]   m_lfsr;
  samp_t       m_pipe [$];
  int          e_sin, e_cos, e_ch;
  bit          e_vld;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic samp_t make_sample(input bit [15:0] p, input int ch);
    samp_t r;
    real   th;
    th   = 2.0 * PI * (real'(int'(p[15:4])) + 0.5) / 4096.0;
    r.s  = rnd(AMP * $sin(th));
    r.c  = rnd(AMP * $cos(th));
    r.ch = ch;
    return r;
  endfunction

  task automatic model_edge();
    bit [31:0] a;
    bit [15:0] p;
    samp_t     o;
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) begin
        m_acc[c] = '0;
        m_phi[c] = '0;
      end
      m_slot = 0;
      m_lfsr = 16'hACE1;
      m_pipe.delete();
      e_sin = 0; e_cos = 0; e_ch = 0; e_vld = 1'b0;
    end else begin
      if (clken) begin
        a = m_acc[m_slot];
        p = a[31:16] + phase_mod_i;
`ifdef NCO_DITHER_EN
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        p = p + {12'd0, m_lfsr[3:0]};
`endif
        m_pipe.push_back(make_sample(p, m_slot));
        if (sync_i) begin
          for (int c = 0; c < 4; c++) m_acc[c] = '0;
        end else begin
          m_acc[m_slot] = a + m_phi[m_slot] + freq_mod_i;
        end
        m_slot = (m_slot + 1) % 4;
        if (m_pipe.size() == 4) begin
          o     = m_pipe.pop_front();
          e_sin = o.s;
          e_cos = o.c;
          e_ch  = o.ch;
          e_vld = 1'b1;
        end
      end
      if (cfg_we) m_phi[cfg_ch] = cfg_phi_inc;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(out_valid), 32'(e_vld));
    chk("sin",   32'(fsin_o),    e_sin);
    chk("cos",   32'(fcos_o),    e_cos);
    chk("ch",    32'(out_ch),    e_ch);
  endtask

  function automatic int tone(input int v);
    case (v % 4)
      0:       return 6;
      1:       return 8191;
      2:       return -6;
      default: return -8191;
    endcase
  endfunction

  function automatic int mc_sin(input int c, input int v);
    if (c == 2) return 6;
    if (c == 1) return (v % 2 == 0) ? 6 : -6;
    return tone(v);
  endfunction

  task automatic load_phi(input bit [31:0] p0, input bit [31:0] p1,
                          input bit [31:0] p2, input bit [31:0] p3);
    bit [31:0] tbl [4];
    tbl = '{p0, p1, p2, p3};
    clken = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cfg_we      = 1'b1;
      cfg_ch      = 2'(c);
      cfg_phi_inc = tbl[c];
      tick();
    end
    cfg_we = 1'b0;
    clken  = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    clken       = 1'b1;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_phi_inc = '0;
    freq_mod_i  = '0;
    phase_mod_i = '0;
    sync_i      = 1'b0;
    tick();
    tick();
    chk("rst_sin", 32'(fsin_o), 0);
    chk("rst_valid", 32'(out_valid), 0);

    // multi-channel tones
    reset_n = 1'b1;
    load_phi(32'h4000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 3) chk("valid_pre", 32'(out_valid), 0);
      if (i == 4) chk("valid_rise", 32'(out_valid), 1);
      if (i >= 4) begin
        chk("mc_ch", 32'(out_ch), (i - 4) % 4);
`ifndef NCO_DITHER_EN
        chk("mc_sin", 32'(fsin_o), mc_sin((i - 4) % 4, (i - 4) / 4));
`endif
      end
    end

    // phase modulation with zero increment
    load_phi(32'h0, 32'h0, 32'h0, 32'h0);
    sync_i      = 1'b1;
    phase_mod_i = 16'd16384;
    tick();
    sync_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
`ifndef NCO_DITHER_EN
      if (i >= 4) begin
        chk("pm_sin", 32'(fsin_o), 8191);
        chk("pm_cos", 32'(fcos_o), -6);
      end
`endif
    end

    // frequency modulation reproduces the single tone; sync restarts at phase 0
    phase_mod_i = '0;
    freq_mod_i  = 32'h4000_0000;
    sync_i      = 1'b1;
    tick();
    sync_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
`ifndef NCO_DITHER_EN
      if (i >= 4) begin
        chk("fm_sin", 32'(fsin_o), tone((i - 4) / 4));
        chk("fm_cos", 32'(fcos_o), tone((i - 4) / 4 + 1));
      end
`endif
    end

    // randomized gaps, modulation, sync, config collisions and a mid-stream reset
    for (int i = 0; i < 500; i++) begin
      clken       = ($urandom_range(0, 9) < 7);
      phase_mod_i = 16'($urandom);
      freq_mod_i  = $urandom;
      sync_i      = ($urandom_range(0, 19) == 0);
      cfg_we      = ($urandom_range(0, 4) == 0);
      cfg_ch      = 2'($urandom_range(0, 3));
      cfg_phi_inc = $urandom;
      reset_n     = (i != 250);
      tick();
      if (i == 250) begin
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sin", 32'(fsin_o), 0);
        chk("mid_rst_cos", 32'(fcos_o), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
